// File: rtl/fifo_push_arbiter.sv
// rtl/fifo_push_arbiter.sv - round-robin FIFO push arbiter with per-requester occupancy quota
module fifo_push_arbiter #(
    parameter int NumReq    = 4,
    parameter int WordWidth = 64,
    parameter int Quota     = 4,
    parameter int IdWidth   = $clog2(NumReq),
    parameter int CntWidth  = $clog2(Quota + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NumReq-1:0]             req_valid_i,
    input  logic [NumReq*WordWidth-1:0]   req_payload_i,
    output logic [NumReq-1:0]             req_ready_o,
    output logic                          fifo_push_o,
    output logic [IdWidth+WordWidth-1:0]  fifo_push_payload_o,
    input  logic                          fifo_full_i,
    input  logic                          fifo_pop_i,
    input  logic [IdWidth-1:0]            fifo_pop_id_i,
    input  logic                          fifo_flush_i,
    output logic [IdWidth-1:0]            grant_id_o,
    output logic [NumReq*CntWidth-1:0]    occupancy_o,
    output logic                          err_o
);

    localparam logic [CntWidth-1:0] QuotaCnt = CntWidth'(Quota);
    localparam logic [IdWidth-1:0]  LastId   = IdWidth'(NumReq - 1);

    logic [IdWidth-1:0]  rr_ptr;
    logic [CntWidth-1:0] occ [NumReq];
    logic                err;

    logic [NumReq-1:0]    elig;
    logic [NumReq-1:0]    inc;
    logic [NumReq-1:0]    dec;
    logic [IdWidth-1:0]   winner;
    logic                 found;
    logic                 go;
    logic                 pop_underflow;
    logic [WordWidth-1:0] payload_sel;

    // A requester competes only while it has a word and is below its quota
    always_comb begin
        elig = '0;
        for (int i = 0; i < NumReq; i++) begin
            elig[i] = req_valid_i[i] && (occ[i] < QuotaCnt);
        end
    end

    // Scan from rr_ptr with wrap; works for non-power-of-two NumReq
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NumReq; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NumReq) begin
                idx = idx - NumReq;
            end
            if (!found && elig[idx]) begin
                found  = 1'b1;
                winner = IdWidth'(idx);
            end
        end
    end

    // Push qualification and the winner's payload/ready
    always_comb begin
        go          = found && !fifo_full_i && !fifo_flush_i && !rst;
        payload_sel = req_payload_i[int'(winner)*WordWidth +: WordWidth];
        req_ready_o = '0;
        if (go) begin
            req_ready_o[winner] = 1'b1;
        end
    end

    assign fifo_push_o         = go;
    assign fifo_push_payload_o = {winner, payload_sel};
    assign grant_id_o          = winner;
    assign err_o               = err;

    // Per-requester credit take/return; a pop of an empty count is an underflow
    always_comb begin
        inc           = '0;
        dec           = '0;
        pop_underflow = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            inc[i] = go && (winner == IdWidth'(i));
            dec[i] = fifo_pop_i && (fifo_pop_id_i == IdWidth'(i)) && (occ[i] != '0);
            if (fifo_pop_i && !fifo_flush_i && (fifo_pop_id_i == IdWidth'(i)) && (occ[i] == '0)) begin
                pop_underflow = 1'b1;
            end
        end
    end

    // Pointer, occupancy and sticky error state; flush drops pops and counts
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            err    <= 1'b0;
            for (int i = 0; i < NumReq; i++) begin
                occ[i] <= '0;
            end
        end else if (fifo_flush_i) begin
            rr_ptr <= '0;
            for (int i = 0; i < NumReq; i++) begin
                occ[i] <= '0;
            end
        end else begin
            if (go) begin
                rr_ptr <= (winner == LastId) ? '0 : winner + 1'b1;
            end
            for (int i = 0; i < NumReq; i++) begin
                if (inc[i] && !dec[i]) begin
                    occ[i] <= occ[i] + 1'b1;
                end else if (dec[i] && !inc[i]) begin
                    occ[i] <= occ[i] - 1'b1;
                end
            end
            if (pop_underflow) begin
                err <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NumReq; g++) begin : g_occ
        assign occupancy_o[g*CntWidth +: CntWidth] = occ[g];
    end

endmodule
